// File: rtl/button_conditioner.sv
// Per-bit push-button front end for an SR latch bank. Each raw level is synchronised,
// debounced, and turned into a one-cycle set pulse on press. Consumer acks become reset pulses.
module button_conditioner #(
  parameter int width         = 8,
  parameter int stable_cycles = 16,
  parameter int cnt_width     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] btn_raw,
  input  logic [width-1:0] clear,
  output logic [width-1:0] s,
  output logic [width-1:0] r,
  output logic [width-1:0] pressed
);

  localparam logic [cnt_width-1:0] last_count = cnt_width'(stable_cycles - 1);
  localparam logic [cnt_width-1:0] one_count  = cnt_width'(1);
  localparam logic [cnt_width-1:0] zero_count = {cnt_width{1'b0}};

  logic [width-1:0]     sync_a_r;
  logic [width-1:0]     sync_b_r;
  logic [width-1:0]     stable_r;
  logic [width-1:0]     stable_next_s;
  logic [width-1:0]     rise_s;
  logic [cnt_width-1:0] count_r      [width];
  logic [cnt_width-1:0] count_next_s [width];

  // Debounce: a level is accepted only after stable_cycles consecutive differing samples.
  always_comb begin
    stable_next_s = stable_r;
    rise_s        = {width{1'b0}};
    for (int i = 0; i < width; i++) begin
      count_next_s[i] = zero_count;
      if (sync_b_r[i] != stable_r[i]) begin
        if (count_r[i] == last_count) begin
          stable_next_s[i] = sync_b_r[i];
          count_next_s[i]  = zero_count;
        end else begin
          count_next_s[i]  = count_r[i] + one_count;
        end
      end else begin
        count_next_s[i] = zero_count;
      end
    end
    rise_s = stable_next_s & ~stable_r;
  end

  // State and output registers; r is forced high through reset so the latch is cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a_r <= {width{1'b0}};
      sync_b_r <= {width{1'b0}};
      stable_r <= {width{1'b0}};
      s        <= {width{1'b0}};
      r        <= {width{1'b1}};
      for (int i = 0; i < width; i++) begin
        count_r[i] <= zero_count;
      end
    end else begin
      sync_a_r <= btn_raw;
      sync_b_r <= sync_a_r;
      stable_r <= stable_next_s;
      s        <= rise_s;
      // A fresh press beats a simultaneous ack, since the latch itself favours r.
      r        <= clear & ~rise_s;
      for (int i = 0; i < width; i++) begin
        count_r[i] <= count_next_s[i];
      end
    end
  end

  assign pressed = stable_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed timing cases plus random presses, acks and resets
// checked every cycle against a sliding-window model of the debounce rule.
module tb_button_conditioner;

  localparam int W = 8;
  localparam int N = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] btn_raw;
  logic [W-1:0] clear;
  logic [W-1:0] s;
  logic [W-1:0] r;
  logic [W-1:0] pressed;

  int total = 0;
  int bad   = 0;

  button_conditioner #(.width(W), .stable_cycles(N), .cnt_width(5)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .clear(clear),
    .s(s), .r(r), .pressed(pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: a new level is accepted when the last N sampled values all differ from it.
  logic [W-1:0] m_sa, m_sb, m_stable, nstab, rise;
  logic [W-1:0] exp_s, exp_r, exp_p;
  logic [N-1:0] win [W];
  int           filled [W];
  bit           model_ok = 1'b0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_sa = '0; m_sb = '0; m_stable = '0;
      for (int i = 0; i < W; i++) begin win[i] = '0; filled[i] = 0; end
      exp_s = '0; exp_r = '1; exp_p = '0;
      model_ok = 1'b1;
    end else begin
      nstab = m_stable;
      for (int i = 0; i < W; i++) begin
        win[i] = {win[i][N-2:0], m_sb[i]};
        if (filled[i] < N) filled[i]++;
        if (filled[i] == N && win[i] == {N{~m_stable[i]}}) nstab[i] = ~m_stable[i];
      end
      rise     = nstab & ~m_stable;
      exp_s    = rise;
      exp_r    = clear & ~rise;
      exp_p    = nstab;
      m_stable = nstab;
      m_sb     = m_sa;
      m_sa     = btn_raw;
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check_val("model_s", s, exp_s);
      check_val("model_r", r, exp_r);
      check_val("model_pressed", pressed, exp_p);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; btn_raw = '0; clear = '0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Runs n edges (numbered from 0) and reports s pulses and pressed transitions on one bit.
  task automatic watch(input int b, input int n, output int first_s, output int n_s,
                       output int first_up, output int first_dn);
    first_s = -1; n_s = 0; first_up = -1; first_dn = -1;
    for (int e = 0; e < n; e++) begin
      tick();
      if (s[b]) begin
        n_s++;
        if (first_s < 0) first_s = e;
      end
      if (pressed[b] && first_up < 0) first_up = e;
      if (!pressed[b] && first_dn < 0) first_dn = e;
    end
  endtask

  int fs, ns, fu, fd, bounce_s;

  initial begin
    reset = 1'b1; btn_raw = 8'hFF; clear = 8'h00;
    @(negedge clk);

    // Reset held three cycles with all buttons down
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("rst_s", s, 8'h00);
      check_val("rst_pressed", pressed, 8'h00);
      check_val("rst_r", r, 8'hFF);
    end
    reset = 1'b0; clear = 8'h5A;
    tick();
    check_val("post_rst_r", r, 8'h5A);
    check_val("post_rst_s", s, 8'h00);

    // Clean press on bit 0
    do_reset(3);
    btn_raw = 8'h01;
    watch(0, 40, fs, ns, fu, fd);
    check_val("clean_first_s", fs, 17);
    check_val("clean_num_s", ns, 1);
    check_val("clean_pressed_edge", fu, 17);

    // Bounce on bit 2, then settle high
    do_reset(3);
    bounce_s = 0;
    for (int seg = 0; seg < 10; seg++) begin
      btn_raw[2] = (seg % 2 == 0);
      for (int k = 0; k < 5; k++) begin
        tick();
        if (s[2]) bounce_s++;
      end
    end
    check_val("bounce_no_s", bounce_s, 0);
    btn_raw[2] = 1'b1;
    watch(2, 30, fs, ns, fu, fd);
    check_val("bounce_first_s", fs, 17);
    check_val("bounce_num_s", ns, 1);

    // Release of bit 3
    do_reset(3);
    btn_raw[3] = 1'b1;
    repeat (25) tick();
    check_val("release_pre", pressed[3], 1);
    btn_raw[3] = 1'b0;
    watch(3, 20, fs, ns, fu, fd);
    check_val("release_drop", fd, 17);
    check_val("release_no_s", ns, 0);

    // Ack colliding with acceptance of bit 1
    do_reset(3);
    btn_raw = 8'h02;
    for (int e = 0; e < 20; e++) begin
      clear = (e == 17 || e == 18) ? 8'h02 : 8'h00;
      tick();
      if (e == 17) begin
        check_val("collide_s", s, 8'h02);
        check_val("collide_r", r, 8'h00);
      end
      if (e == 18) begin
        check_val("collide_next_r", r, 8'h02);
        check_val("collide_next_s", s, 8'h00);
      end
    end
    clear = 8'h00;

    // Reset in the middle of a debounce count on bit 5
    do_reset(3);
    btn_raw[5] = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    watch(5, 30, fs, ns, fu, fd);
    check_val("midrst_first_s", fs, 17);
    check_val("midrst_num_s", ns, 1);

    // Random presses, bounces, acks and occasional resets
    do_reset(2);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 23) == 0) btn_raw[i] = ~btn_raw[i];
      end
      clear = 8'($urandom) & 8'($urandom) & 8'($urandom);
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Per-bit input stage that sits directly upstream of the SR latch bank. Takes raw, asynchronous push-button levels and produces clean single-cycle set pulses (s) and clear pulses (r) that drive the latch's s/r inputs. Each bit is synchronised, debounced and rising-edge detected. A consumer acknowledge (clear) is turned into a registered reset pulse, so latched presses are held until the game FSM consumes them.

Parameters:
width, 8, number of independent button channels; matches the latch bank width.
stable_cycles, 16, consecutive differing samples required to accept a new level; must be >= 2.
cnt_width, 5, debounce counter width per channel; must satisfy 2**cnt_width > stable_cycles.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
btn_raw  input  width  raw asynchronous button levels, 1 = pressed.
clear  input  width  per-bit acknowledge from consumer; a level, sampled every cycle.
s  output  width  registered set pulses to the latch; one cycle per accepted press.
r  output  width  registered reset pulses to the latch.
pressed  output  width  debounced stable level per channel.

Behaviour:
- One clock; reset is synchronous and active-high; no other clock or reset.
- Reset (reset=1 at a rising clk edge): sync flops, stable levels, counters, s and pressed all go to 0; r goes to all ones. This holds r high for every reset cycle so the unclocked latch is cleared. Reset mid-debounce discards any partial count.
- Synchroniser: two flops per bit (sync_a <= btn_raw; sync_b <= sync_a). Only sync_b is used downstream.
- Debounce, per bit, evaluated every edge:
  - sync_b == stable: count <= 0.
  - sync_b != stable and count < stable_cycles-1: count <= count+1.
  - sync_b != stable and count == stable_cycles-1: stable <= sync_b; count <= 0.
  - A new level is therefore accepted on the stable_cycles-th consecutive edge with sync_b differing. Any single matching sample restarts the count.
- pressed = stable (registered).
- s[i] <= rise[i], where rise[i] = the edge at which stable[i] goes 0->1. s is high for exactly one cycle per accepted press. Release (1->0) produces no pulse.
- r[i] <= clear[i] & ~rise[i]. If a new press and clear coincide on the same bit and edge, s wins and r is suppressed, because the latch itself gives r priority and the newer press must not be lost.
- Holding clear high yields r high every cycle, with the exception above.
- Latency: btn_raw stable from before edge E0 -> sync_b changes at E0+1 -> stable updates at E0+1+stable_cycles -> s high for the cycle after that edge. With default 16, s is high between edges 17 and 18 after the first sampling edge.
- Channels are fully independent; simultaneous presses on several bits give simultaneous s bits.
- Counter never wraps: it saturates by acceptance at stable_cycles-1.
- A held button produces exactly one s pulse, regardless of hold length.

Test Plan:
- Reset: assert reset 3 cycles with btn_raw=8'hFF -> during reset s=0, pressed=0, r=8'hFF; first cycle after release r=clear.
- Clean press: btn_raw[0] 0->1 sampled at edge 0, held 40 cycles (stable_cycles=16) -> s=8'h01 for exactly one cycle, after edge 17; pressed[0]=1 from the same edge; no further s pulses.
- Bounce: btn_raw[2] toggles every 5 cycles for 50 cycles, then settles at 1 -> no s pulse during the bounce; one s=8'h04 pulse 17 edges after settling.
- Release: from pressed[3]=1, btn_raw[3] -> 0 held 20 cycles -> pressed[3] drops after 17 edges; s stays 0.
- Clear/press collision: clear=8'h02 on the same edge that bit 1 is accepted -> s=8'h02, r=8'h00 that cycle; the next cycle r=8'h02.
- Reset mid-count: btn_raw[5]=1 for 10 cycles, pulse reset once, keep btn_raw[5]=1 -> s[5] pulses 17 edges after reset deasserts, not earlier.
